// File: rtl/matrix_scan_controller.sv
// Column-scan sequencer for a 5x7 LED matrix: one-hot column strobe held for DWELL
// cycles per phase, with a double-buffered frame that only swaps at a frame boundary.
//
// state | meaning
// ------+---------------------------------------------
// BLANK | ring 000, display blanked (enable low or just reset)
// PH_A  | ring 001, columns 0&4 strobed, frame start
// PH_B  | ring 010, columns 1&3 strobed
// PH_C  | ring 100, column 2 strobed, last phase of the frame
module matrix_scan_controller #(
    parameter int unsigned DWELL = 50000,
    parameter int unsigned CNT_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_valid,
    output logic       frame_ready,
    input  logic [6:0] frame_col2,
    input  logic [6:0] frame_col1,
    input  logic [6:0] frame_col0,
    output logic [2:0] ring_counter,
    output logic [6:0] col_2,
    output logic [6:0] col_1,
    output logic [6:0] col_0,
    output logic       frame_tick
);

    typedef enum logic [2:0] {
        BLANK = 3'b000,
        PH_A  = 3'b001,
        PH_B  = 3'b010,
        PH_C  = 3'b100
    } phase_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic [6:0]       act2_q, act2_d, act1_q, act1_d, act0_q, act0_d;
    logic [6:0]       pend2_q, pend2_d, pend1_q, pend1_d, pend0_q, pend0_d;
    logic             pend_full_q, pend_full_d;
    logic             commit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q     <= BLANK;
            cnt_q       <= '0;
            tick_q      <= 1'b0;
            act2_q      <= '0;
            act1_q      <= '0;
            act0_q      <= '0;
            pend2_q     <= '0;
            pend1_q     <= '0;
            pend0_q     <= '0;
            pend_full_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            act2_q      <= act2_d;
            act1_q      <= act1_d;
            act0_q      <= act0_d;
            pend2_q     <= pend2_d;
            pend1_q     <= pend1_d;
            pend0_q     <= pend0_d;
            pend_full_q <= pend_full_d;
        end
    end

    // Phase sequencing; commit marks the edges where swapping frames cannot tear.
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        commit  = 1'b0;
        if (!enable) begin
            phase_d = BLANK;
            cnt_d   = '0;
            commit  = pend_full_q;
        end else begin
            case (phase_q)
                BLANK: begin
                    phase_d = PH_A;
                    cnt_d   = '0;
                    tick_d  = 1'b1;
                end
                PH_A, PH_B, PH_C: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        case (phase_q)
                            PH_A:    phase_d = PH_B;
                            PH_B:    phase_d = PH_C;
                            default: begin
                                phase_d = PH_A;
                                tick_d  = 1'b1;
                                commit  = pend_full_q;
                            end
                        endcase
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    phase_d = BLANK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Accept and commit never coincide: accept needs pend_full low, commit needs it high.
    always_comb begin
        act2_d      = act2_q;
        act1_d      = act1_q;
        act0_d      = act0_q;
        pend2_d     = pend2_q;
        pend1_d     = pend1_q;
        pend0_d     = pend0_q;
        pend_full_d = pend_full_q;
        if (commit) begin
            act2_d      = pend2_q;
            act1_d      = pend1_q;
            act0_d      = pend0_q;
            pend_full_d = 1'b0;
        end
        if (frame_valid && !pend_full_q) begin
            pend2_d     = frame_col2;
            pend1_d     = frame_col1;
            pend0_d     = frame_col0;
            pend_full_d = 1'b1;
        end
    end

    assign ring_counter = phase_q;
    assign frame_tick   = tick_q;
    assign frame_ready  = !pend_full_q;
    assign col_2        = act2_q;
    assign col_1        = act1_q;
    assign col_0        = act0_q;

endmodule
